// File: rtl/extremum_tracker_if.sv
// Sample/result bus of the extremum tracker.
// The master side drives samples and consumes results; the slave side
// is the tracker itself.
interface extremum_tracker_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_CH  = 4,
    parameter int COUNT_W = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Frame control
    logic               clr;
    logic               mode_min;

    // Sample stream
    logic               in_valid;
    logic               in_ready;
    logic [CH_W-1:0]    in_ch;
    logic [WIDTH-1:0]   in_data;
    logic               in_last;

    // Result stream
    logic               out_valid;
    logic               out_ready;
    logic [CH_W-1:0]    out_ch;
    logic [WIDTH-1:0]   out_ext;
    logic [COUNT_W-1:0] out_idx;
    logic [COUNT_W-1:0] out_count;

    modport master (
        output clr,
        output mode_min,
        output in_valid,
        input  in_ready,
        output in_ch,
        output in_data,
        output in_last,
        input  out_valid,
        output out_ready,
        input  out_ch,
        input  out_ext,
        input  out_idx,
        input  out_count
    );

    modport slave (
        input  clr,
        input  mode_min,
        input  in_valid,
        output in_ready,
        input  in_ch,
        input  in_data,
        input  in_last,
        output out_valid,
        input  out_ready,
        output out_ch,
        output out_ext,
        output out_idx,
        output out_count
    );
endinterface

// File: rtl/extremum_tracker.sv
// Per-channel running maximum/minimum tracker.
// Each channel accumulates a frame of samples, remembering the extremum,
// the zero-based position where it first occurred and the sample count.
// The sample that closes a frame moves the block into REPORT, where that
// channel's result is held until consumed; consuming it clears the channel.
module extremum_tracker #(
    parameter int WIDTH   = 8,
    parameter int NUM_CH  = 4,
    parameter int COUNT_W = 16,
    parameter bit SIGNED  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    extremum_tracker_if.slave bus
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Per-channel state
    logic [WIDTH-1:0]   r_ext  [NUM_CH];
    logic [COUNT_W-1:0] r_idx  [NUM_CH];
    logic [COUNT_W-1:0] r_cnt  [NUM_CH];
    logic               r_seen [NUM_CH];
    logic               r_mode [NUM_CH];

    // Result registers
    logic [CH_W-1:0]    r_out_ch;
    logic [WIDTH-1:0]   r_out_ext;
    logic [COUNT_W-1:0] r_out_idx;
    logic [COUNT_W-1:0] r_out_cnt;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_ch_ok;
    logic               w_take;
    logic               w_drain;
    logic [CH_W-1:0]    w_sel;
    logic               w_first;
    logic [WIDTH-1:0]   w_new_ext;
    logic [COUNT_W-1:0] w_new_idx;
    logic [COUNT_W-1:0] w_new_cnt;
    logic               w_new_mode;

    // True when sample a should replace the stored extremum b. Both values
    // are widened by one bit so the same signed compare serves both the
    // two's-complement and the unsigned interpretation.
    function automatic logic f_better(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             min_mode
    );
        logic signed [WIDTH:0] sa;
        logic signed [WIDTH:0] sb;
        sa = SIGNED ? $signed({a[WIDTH-1], a}) : $signed({1'b0, a});
        sb = SIGNED ? $signed({b[WIDTH-1], b}) : $signed({1'b0, b});
        return min_mode ? (sa < sb) : (sa > sb);
    endfunction

    // Sample counter increment that sticks at all-ones.
    function automatic logic [COUNT_W-1:0] f_sat_inc(input logic [COUNT_W-1:0] c);
        return (&c) ? c : c + COUNT_W'(1);
    endfunction

    // Samples are only taken while accumulating, outside reset and clear.
    assign w_in_ready = rst_n && (r_state == ACCUM) && !bus.clr;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_ch_ok    = (int'(bus.in_ch) < NUM_CH);
    // Out-of-range channels are accepted but never touch any state.
    assign w_take     = w_accept && w_ch_ok;
    assign w_drain    = (r_state == REPORT) && bus.out_ready && !bus.clr;

    // Next-state and result-valid decode; clr always returns to ACCUM.
    always_comb begin
        w_state_nxt = r_state;
        w_out_valid = 1'b0;
        case (r_state)
            ACCUM: begin
                if (w_take && bus.in_last) begin
                    w_state_nxt = REPORT;
                end
            end
            REPORT: begin
                w_out_valid = 1'b1;
                if (bus.clr || bus.out_ready) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: begin
                w_state_nxt = ACCUM;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Updated channel values for the incoming sample; the mode is latched
    // on the first sample so later mode_min changes cannot flip a frame.
    always_comb begin
        w_sel      = w_ch_ok ? bus.in_ch : '0;
        w_first    = !r_seen[w_sel];
        w_new_ext  = r_ext[w_sel];
        w_new_idx  = r_idx[w_sel];
        w_new_cnt  = f_sat_inc(r_cnt[w_sel]);
        w_new_mode = r_mode[w_sel];
        if (w_first) begin
            w_new_ext  = bus.in_data;
            w_new_idx  = '0;
            w_new_cnt  = COUNT_W'(1);
            w_new_mode = bus.mode_min;
        end else if (f_better(bus.in_data, r_ext[w_sel], r_mode[w_sel])) begin
            // Strict compare keeps the earliest index on ties; the current
            // count is the new sample's position (saturated if need be).
            w_new_ext = bus.in_data;
            w_new_idx = r_cnt[w_sel];
        end
    end

    // Channel state and result capture; consuming a result clears only
    // the reported channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_ext[i]  <= '0;
                r_idx[i]  <= '0;
                r_cnt[i]  <= '0;
                r_seen[i] <= 1'b0;
                r_mode[i] <= 1'b0;
            end
            r_out_ch  <= '0;
            r_out_ext <= '0;
            r_out_idx <= '0;
            r_out_cnt <= '0;
        end else if (bus.clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_ext[i]  <= '0;
                r_idx[i]  <= '0;
                r_cnt[i]  <= '0;
                r_seen[i] <= 1'b0;
                r_mode[i] <= 1'b0;
            end
            r_out_ch  <= '0;
            r_out_ext <= '0;
            r_out_idx <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_take) begin
                r_ext[w_sel]  <= w_new_ext;
                r_idx[w_sel]  <= w_new_idx;
                r_cnt[w_sel]  <= w_new_cnt;
                r_seen[w_sel] <= 1'b1;
                r_mode[w_sel] <= w_new_mode;
                if (bus.in_last) begin
                    r_out_ch  <= w_sel;
                    r_out_ext <= w_new_ext;
                    r_out_idx <= w_new_idx;
                    r_out_cnt <= w_new_cnt;
                end
            end
            if (w_drain) begin
                r_ext[r_out_ch]  <= '0;
                r_idx[r_out_ch]  <= '0;
                r_cnt[r_out_ch]  <= '0;
                r_seen[r_out_ch] <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_ext   = r_out_ext;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_count = r_out_cnt;

endmodule

// File: tb/tb_extremum_tracker.sv
// Bench for extremum_tracker: two instances (unsigned/4 channels/16-bit
// counters and signed/3 channels/3-bit counters) driven by directed frames.
// Expected results are queued at stimulus time and popped by per-instance
// monitors whenever a result is handed over.
module tb_extremum_tracker;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    extremum_tracker_if #(.WIDTH(8), .NUM_CH(4), .COUNT_W(16)) bus_a ();
    extremum_tracker_if #(.WIDTH(8), .NUM_CH(3), .COUNT_W(3))  bus_b ();

    extremum_tracker #(.WIDTH(8), .NUM_CH(4), .COUNT_W(16), .SIGNED(1'b0)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    extremum_tracker #(.WIDTH(8), .NUM_CH(3), .COUNT_W(3), .SIGNED(1'b1)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    typedef struct {
        int ch;
        int ext;
        int idx;
        int cnt;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input bit sel_b, input int ch, input int ext, input int idx, input int cnt);
        exp_t e;
        e.ch = ch; e.ext = ext; e.idx = idx; e.cnt = cnt;
        if (sel_b) qb.push_back(e);
        else       qa.push_back(e);
    endtask

    task automatic drive_in(input bit sel_b, input bit vld, input int ch, input int data,
                            input bit last, input bit mode);
        if (sel_b) begin
            bus_b.in_valid = vld;
            bus_b.in_ch    = 2'(ch);
            bus_b.in_data  = 8'(data);
            bus_b.in_last  = last;
            bus_b.mode_min = mode;
        end else begin
            bus_a.in_valid = vld;
            bus_a.in_ch    = 2'(ch);
            bus_a.in_data  = 8'(data);
            bus_a.in_last  = last;
            bus_a.mode_min = mode;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and hold it until the accepting edge has passed.
    task automatic send(input bit sel_b, input int ch, input int data, input bit last, input bit mode);
        bit done;
        int guard;
        done  = 1'b0;
        guard = 0;
        drive_in(sel_b, 1'b1, ch, data, last, mode);
        while (!done && guard < 40) begin
            @(negedge clk);
            done = sel_b ? bus_b.in_ready : bus_a.in_ready;
            step();
            guard++;
        end
        if (!done) chk("send timeout (accepted)", 0, 1);
        drive_in(sel_b, 1'b0, 0, 0, 1'b0, mode);
    endtask

    // Monitor for instance A: compare every handed-over result.
    always @(negedge clk) begin
        if (bus_a.out_valid === 1'b1 && bus_a.out_ready === 1'b1) begin
            if (qa.size() == 0) begin
                chk("A unexpected result (pending)", 0, 1);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("A out_ch",    bus_a.out_ch,    e.ch);
                chk("A out_ext",   bus_a.out_ext,   e.ext);
                chk("A out_idx",   bus_a.out_idx,   e.idx);
                chk("A out_count", bus_a.out_count, e.cnt);
            end
        end
    end

    // Monitor for instance B.
    always @(negedge clk) begin
        if (bus_b.out_valid === 1'b1 && bus_b.out_ready === 1'b1) begin
            if (qb.size() == 0) begin
                chk("B unexpected result (pending)", 0, 1);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("B out_ch",    bus_b.out_ch,    e.ch);
                chk("B out_ext",   bus_b.out_ext,   e.ext);
                chk("B out_idx",   bus_b.out_idx,   e.idx);
                chk("B out_count", bus_b.out_count, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        rst_n = 1'b0;
        bus_a.clr = 1'b0;
        bus_b.clr = 1'b0;
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        drive_in(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        drive_in(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

        // Reset state of both instances
        #12;
        chk("A rst out_valid", bus_a.out_valid, 0);
        chk("A rst out_ch",    bus_a.out_ch,    0);
        chk("A rst out_ext",   bus_a.out_ext,   0);
        chk("A rst out_idx",   bus_a.out_idx,   0);
        chk("A rst out_count", bus_a.out_count, 0);
        chk("A rst in_ready",  bus_a.in_ready,  0);
        chk("B rst out_valid", bus_b.out_valid, 0);
        chk("B rst in_ready",  bus_b.in_ready,  0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("A in_ready after release", bus_a.in_ready, 1);
        chk("B in_ready after release", bus_b.in_ready, 1);
        step();

        // Max frame 3,9,9,2: tie keeps first 9
        push(1'b0, 0, 9, 1, 4);
        send(1'b0, 0, 3, 1'b0, 1'b0);
        send(1'b0, 0, 9, 1'b0, 1'b0);
        send(1'b0, 0, 9, 1'b0, 1'b0);
        send(1'b0, 0, 2, 1'b1, 1'b0);
        @(negedge clk);
        chk("A out_valid one cycle after last", bus_a.out_valid, 1);
        step();
        @(negedge clk);
        chk("A out_valid after handshake", bus_a.out_valid, 0);
        step();

        // Min frame 0x05,0xF0,0x7F unsigned on A, signed on B
        push(1'b0, 2, 8'h05, 0, 3);
        send(1'b0, 2, 8'h05, 1'b0, 1'b1);
        send(1'b0, 2, 8'hF0, 1'b0, 1'b1);
        send(1'b0, 2, 8'h7F, 1'b1, 1'b1);
        push(1'b1, 2, 8'hF0, 1, 3);
        send(1'b1, 2, 8'h05, 1'b0, 1'b1);
        send(1'b1, 2, 8'hF0, 1'b0, 1'b1);
        send(1'b1, 2, 8'h7F, 1'b1, 1'b1);
        step();

        // Mode latched on first sample: later mode_min=1 is ignored
        push(1'b0, 0, 8, 2, 3);
        send(1'b0, 0, 5, 1'b0, 1'b0);
        send(1'b0, 0, 3, 1'b0, 1'b1);
        send(1'b0, 0, 8, 1'b1, 1'b1);
        step();

        // Interleave with backpressure
        push(1'b0, 3, 1, 0, 1);
        push(1'b0, 1, 7, 1, 3);
        send(1'b0, 1, 4, 1'b0, 1'b0);
        send(1'b0, 1, 7, 1'b0, 1'b0);
        bus_a.out_ready = 1'b0;
        send(1'b0, 3, 1, 1'b1, 1'b0);
        drive_in(1'b0, 1'b1, 1, 6, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("A stall in_ready",  bus_a.in_ready,  0);
            chk("A stall out_valid", bus_a.out_valid, 1);
            chk("A stall out_ch",    bus_a.out_ch,    3);
            chk("A stall out_ext",   bus_a.out_ext,   1);
            chk("A stall out_idx",   bus_a.out_idx,   0);
            chk("A stall out_count", bus_a.out_count, 1);
            step();
        end
        bus_a.out_ready = 1'b1;
        send(1'b0, 1, 6, 1'b1, 1'b0);
        step();

        // clr during REPORT with a sample presented
        send(1'b0, 1, 100, 1'b0, 1'b0);
        bus_a.out_ready = 1'b0;
        send(1'b0, 0, 1, 1'b0, 1'b0);
        send(1'b0, 0, 2, 1'b1, 1'b0);
        bus_a.clr = 1'b1;
        drive_in(1'b0, 1'b1, 1, 50, 1'b1, 1'b0);
        @(negedge clk);
        chk("A clr in_ready",        bus_a.in_ready,  0);
        chk("A out_valid before clr", bus_a.out_valid, 1);
        step();
        bus_a.clr = 1'b0;
        drive_in(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("A clr drops out_valid", bus_a.out_valid, 0);
        step();
        bus_a.out_ready = 1'b1;
        push(1'b0, 0, 7, 0, 1);
        send(1'b0, 0, 7, 1'b1, 1'b0);
        push(1'b0, 1, 20, 0, 1);
        send(1'b0, 1, 20, 1'b1, 1'b0);
        step();

        // Count saturation on B (3-bit counters)
        push(1'b1, 0, 19, 7, 7);
        for (int i = 0; i < 10; i++) begin
            send(1'b1, 0, 10 + i, (i == 9), 1'b0);
        end
        step();

        // Out-of-range channel with last is swallowed on B
        push(1'b1, 0, 5, 0, 2);
        send(1'b1, 0, 5, 1'b0, 1'b0);
        send(1'b1, 3, 200, 1'b1, 1'b0);
        @(negedge clk);
        chk("B out-of-range no result", bus_b.out_valid, 0);
        step();
        send(1'b1, 0, 4, 1'b1, 1'b0);
        step();

        // Reset mid-frame and mid-REPORT
        send(1'b0, 2, 33, 1'b0, 1'b0);
        send(1'b0, 2, 44, 1'b0, 1'b0);
        bus_a.out_ready = 1'b0;
        send(1'b0, 1, 9, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("A mid rst out_valid", bus_a.out_valid, 0);
        chk("A mid rst out_ch",    bus_a.out_ch,    0);
        chk("A mid rst out_ext",   bus_a.out_ext,   0);
        chk("A mid rst out_idx",   bus_a.out_idx,   0);
        chk("A mid rst out_count", bus_a.out_count, 0);
        chk("A mid rst in_ready",  bus_a.in_ready,  0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        bus_a.out_ready = 1'b1;
        @(negedge clk);
        chk("A in_ready after mid rst", bus_a.in_ready, 1);
        step();
        push(1'b0, 2, 50, 0, 1);
        send(1'b0, 2, 50, 1'b1, 1'b0);

        // Drain outstanding expectations
        g = 0;
        while ((qa.size() != 0 || qb.size() != 0) && g < 50) begin
            step();
            g++;
        end
        step();
        chk("A results outstanding", qa.size(), 0);
        chk("B results outstanding", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/extremum_tracker.md
EXTREMUM_TRACKER -- requirements
Module: extremum_tracker

Interface
REQ-001 Parameter WIDTH, default 8, sample width in bits.
REQ-002 Parameter NUM_CH, default 4, number of independent channels; CH_W = max(1, clog2(NUM_CH)).
REQ-003 Parameter COUNT_W, default 16, width of the sample counter and index fields.
REQ-004 Parameter SIGNED, default 0; 1 = two's-complement compare, 0 = unsigned compare.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 clr  input  1  synchronous clear of all channels.
REQ-008 mode_min  input  1  0 = track maximum, 1 = track minimum.
REQ-009 in_valid  input  1  sample present.
REQ-010 in_ready  output  1  sample may be accepted.
REQ-011 in_ch  input  CH_W  channel of sample.
REQ-012 in_data  input  WIDTH  sample value.
REQ-013 in_last  input  1  sample closes its channel's frame.
REQ-014 out_valid  output  1  frame result present.
REQ-015 out_ready  input  1  result consumed.
REQ-016 out_ch, out_ext, out_idx, out_count  output  CH_W, WIDTH, COUNT_W, COUNT_W  channel, extremum value, zero-based index of extremum, samples in frame.

Function
REQ-017 Per channel the block SHALL hold: ext (WIDTH), idx, count (COUNT_W each), seen flag, and latched mode.
REQ-018 FSM SHALL have two states: ACCUM (accept samples) and REPORT (present one result).
REQ-019 in_ready SHALL be 1 only in ACCUM with clr low; a sample is accepted when in_valid and in_ready are both 1.
REQ-020 A sample with in_ch >= NUM_CH SHALL be accepted and discarded with no state change, including when in_last = 1.
REQ-021 On the first accepted sample of a frame (seen = 0): ext <= in_data, idx <= 0, count <= 1, seen <= 1, channel mode <= mode_min.
REQ-022 On later samples: if in_data is strictly greater (mode 0) or strictly less (mode 1) than ext under the SIGNED rule, ext <= in_data and idx <= count; count <= count + 1 in every case.
REQ-023 Ties SHALL keep the earliest index.
REQ-024 count SHALL saturate at 2^COUNT_W - 1; once saturated, idx updates use the saturated value.
REQ-025 mode_min changes SHALL NOT affect a channel whose seen = 1.
REQ-026 An accepted in_last sample SHALL be included in the result; on the next edge the FSM SHALL enter REPORT with out_valid = 1 and out_* holding the updated channel values (latency 1 cycle from acceptance).
REQ-027 out_* SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-028 On out_valid and out_ready both 1: that channel's seen, count, idx, and ext SHALL clear to 0, out_valid SHALL go 0, and the FSM SHALL return to ACCUM on the same edge.
REQ-029 Other channels SHALL retain their state across a REPORT.
REQ-030 clr = 1 SHALL on the next edge: clear all channels, drop out_valid, and force ACCUM; a sample presented in the same cycle is not accepted; clr has priority over out_ready.

Reset
REQ-031 rst_n = 0 SHALL asynchronously force ACCUM and clear all channel state.
REQ-032 rst_n = 0 SHALL asynchronously drive out_valid, out_ch, out_ext, out_idx, and out_count to 0.
REQ-033 in_ready SHALL be 0 while rst_n = 0, and 1 in the first cycle after release, provided clr = 0.
REQ-034 A reset mid-frame or mid-REPORT SHALL discard all partial results.

Verification
REQ-035 Max frame: ch0 samples 3,9,9,2(last), mode 0, WIDTH 8 -> out_ch 0, ext 9, idx 1, count 4, out_valid one cycle after last.
REQ-036 Signed min with SIGNED=1: ch2 samples 0x05, 0xF0, 0x7F(last), mode 1 -> ext 0xF0, idx 1, count 3; with SIGNED=0 -> ext 0x05, idx 0.
REQ-037 Interleave/backpressure: ch1 sends 4,7; ch3 sends 1(last) while out_ready held 0 for 5 cycles -> in_ready 0 and out_* stable throughout; ch3 result (1,0,1) is delivered, after which ch1 continues with 6(last) -> ext 7, idx 1, count 3.
REQ-038 Saturation with COUNT_W=3: ch0 sends 10 samples of increasing value -> count 7, idx 7, ext equals the last value.
REQ-039 Clear/reset: clr asserted during REPORT together with in_valid -> out_valid 0 and the sample is dropped; rst_n pulsed low mid-frame -> all outputs 0 and the next frame starts at count 1.
